// File: rtl/status_scan_scheduler.sv
// status_scan_scheduler
//
// Shares one status-to-digit decoder across N_CH 2-bit status channels.
// Each digit is selected for SCAN_DIV clocks, round-robin. All channels are
// captured into snapshot registers together, at frame boundaries, through a
// req/ack handshake. A channel whose snapshot value changes gets a sticky
// changed flag, and the digit for that channel blinks.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   enable       scan enable; low blanks the display and halts the scan
//   std_in       live statuses, channel i at [2i+1:2i]
//   upd_req      snapshot request (level, held until upd_ack)
//   upd_ack      one-cycle pulse on the cycle the snapshot registers load
//   clr_changed  clears all changed flags
//   std_out      snapshot status of the current channel (decoder input)
//   dig_sel      one-hot active-low digit enables
//   ch_idx       current channel index
//   frame_tick   one-cycle pulse when ch_idx wraps N_CH-1 -> 0
//   changed      sticky per-channel change flags
module status_scan_scheduler #(
    parameter int N_CH         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [2*N_CH-1:0]       std_in,
    input  logic                    upd_req,
    output logic                    upd_ack,
    input  logic                    clr_changed,
    output logic [1:0]              std_out,
    output logic [N_CH-1:0]         dig_sel,
    output logic [$clog2(N_CH)-1:0] ch_idx,
    output logic                    frame_tick,
    output logic [N_CH-1:0]         changed
);

    localparam int CW = $clog2(N_CH);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] LAST_CH    = CW'(N_CH - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

    // State registers
    logic [PW-1:0]       presc_r;
    logic [CW-1:0]       ch_idx_r;
    logic                run_r;        // scan was running last cycle
    logic [2*N_CH-1:0]   snap_r;
    logic [N_CH-1:0]     changed_r;
    logic                phase_r;      // 0 = visible, 1 = hidden
    logic [BW-1:0]       blink_cnt_r;
    logic [1:0]          std_out_r;
    logic [N_CH-1:0]     dig_sel_r;
    logic                upd_ack_r;
    logic                frame_tick_r;

    // Next-state values
    logic                slot_end_s;
    logic                wrap_s;
    logic                load_s;
    logic [PW-1:0]       presc_nxt_s;
    logic [CW-1:0]       ch_nxt_s;
    logic [2*N_CH-1:0]   snap_nxt_s;
    logic [N_CH-1:0]     changed_nxt_s;
    logic                phase_nxt_s;
    logic [BW-1:0]       blink_cnt_nxt_s;
    logic [1:0]          std_out_nxt_s;
    logic [N_CH-1:0]     dig_sel_nxt_s;

    assign ch_idx     = ch_idx_r;
    assign std_out    = std_out_r;
    assign dig_sel    = dig_sel_r;
    assign upd_ack    = upd_ack_r;
    assign frame_tick = frame_tick_r;
    assign changed    = changed_r;

    // Scan position: the first enabled cycle after reset or after a disabled
    // period only (re)starts at channel 0 slot 0, so that slot gets its full
    // SCAN_DIV length. Counting starts on the following cycle.
    always_comb begin
        presc_nxt_s = '0;
        ch_nxt_s    = '0;
        slot_end_s  = enable & run_r & (presc_r == LAST_PRESC);
        wrap_s      = slot_end_s & (ch_idx_r == LAST_CH);
        if (enable && run_r) begin
            if (slot_end_s) begin
                presc_nxt_s = '0;
                if (ch_idx_r == LAST_CH) begin
                    ch_nxt_s = '0;
                end else begin
                    ch_nxt_s = ch_idx_r + CW'(1);
                end
            end else begin
                presc_nxt_s = presc_r + PW'(1);
                ch_nxt_s    = ch_idx_r;
            end
        end else begin
            presc_nxt_s = '0;
            ch_nxt_s    = '0;
        end
    end

    // Snapshot load and change flags. A request is not served on the cycle
    // right after an ack, which keeps upd_ack a single-cycle pulse while the
    // requester is still dropping upd_req. A set beats a same-cycle clear.
    always_comb begin
        snap_nxt_s    = snap_r;
        changed_nxt_s = changed_r;
        if (enable) begin
            load_s = upd_req & ~upd_ack_r & wrap_s;
        end else begin
            load_s = upd_req & ~upd_ack_r;
        end
        if (clr_changed) begin
            changed_nxt_s = '0;
        end else begin
            changed_nxt_s = changed_r;
        end
        if (load_s) begin
            snap_nxt_s = std_in;
            for (int i = 0; i < N_CH; i++) begin
                if (std_in[2*i +: 2] != snap_r[2*i +: 2]) begin
                    changed_nxt_s[i] = 1'b1;
                end else begin
                    changed_nxt_s[i] = changed_nxt_s[i];
                end
            end
        end else begin
            snap_nxt_s = snap_r;
        end
    end

    // Blink phase toggles every BLINK_FRAMES frame wraps; held otherwise.
    always_comb begin
        phase_nxt_s     = phase_r;
        blink_cnt_nxt_s = blink_cnt_r;
        if (wrap_s) begin
            if (blink_cnt_r == LAST_BLINK) begin
                blink_cnt_nxt_s = '0;
                phase_nxt_s     = ~phase_r;
            end else begin
                blink_cnt_nxt_s = blink_cnt_r + BW'(1);
                phase_nxt_s     = phase_r;
            end
        end else begin
            blink_cnt_nxt_s = blink_cnt_r;
            phase_nxt_s     = phase_r;
        end
    end

    // Display outputs come from next-state values, so std_out, dig_sel and
    // ch_idx all change on the same edge and reflect a fresh snapshot at once.
    always_comb begin
        std_out_nxt_s = 2'b00;
        dig_sel_nxt_s = '1;
        if (enable) begin
            std_out_nxt_s = snap_nxt_s[{ch_nxt_s, 1'b0} +: 2];
            if (changed_nxt_s[ch_nxt_s] && phase_nxt_s) begin
                dig_sel_nxt_s = '1;
            end else begin
                dig_sel_nxt_s           = '1;
                dig_sel_nxt_s[ch_nxt_s] = 1'b0;
            end
        end else begin
            std_out_nxt_s = 2'b00;
            dig_sel_nxt_s = '1;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_r      <= '0;
            ch_idx_r     <= '0;
            run_r        <= 1'b0;
            snap_r       <= '0;
            changed_r    <= '0;
            phase_r      <= 1'b0;
            blink_cnt_r  <= '0;
            std_out_r    <= 2'b00;
            dig_sel_r    <= '1;
            upd_ack_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            presc_r      <= presc_nxt_s;
            ch_idx_r     <= ch_nxt_s;
            run_r        <= enable;
            snap_r       <= snap_nxt_s;
            changed_r    <= changed_nxt_s;
            phase_r      <= phase_nxt_s;
            blink_cnt_r  <= blink_cnt_nxt_s;
            std_out_r    <= std_out_nxt_s;
            dig_sel_r    <= dig_sel_nxt_s;
            upd_ack_r    <= load_s;
            frame_tick_r <= wrap_s;
        end
    end

endmodule

// File: tb/tb_status_scan_scheduler.sv
// Directed bench for status_scan_scheduler with N_CH=4, SCAN_DIV=3,
// BLINK_FRAMES=2. Outputs are sampled 1 time unit after each rising edge.
// Step s counts edges since the scan (re)started; s=1 shows ch0 slot 0,
// frame ticks land on s=13, 25, 37, ...
module tb_status_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] std_in;
    logic       upd_req;
    logic       upd_ack;
    logic       clr_changed;
    logic [1:0] std_out;
    logic [3:0] dig_sel;
    logic [1:0] ch_idx;
    logic       frame_tick;
    logic [3:0] changed;

    int n_tests = 0;
    int n_fail  = 0;
    int s       = 0;

    status_scan_scheduler #(
        .N_CH(4),
        .SCAN_DIV(3),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .std_in(std_in),
        .upd_req(upd_req),
        .upd_ack(upd_ack),
        .clr_changed(clr_changed),
        .std_out(std_out),
        .dig_sel(dig_sel),
        .ch_idx(ch_idx),
        .frame_tick(frame_tick),
        .changed(changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig;
        logic [1:0] so;
        logic [1:0] ch;
        logic       ft;
    } vec_t;

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
        s++;
    endtask

    task automatic run_to(input int target);
        while (s < target) step();
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (s=%0d): got %b expected %b", name, s, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dig"},  8'(dig_sel),    8'b0000_1111);
        chk({tag, "_so"},   8'(std_out),    8'h00);
        chk({tag, "_ch"},   8'(ch_idx),     8'h00);
        chk({tag, "_ack"},  8'(upd_ack),    8'h00);
        chk({tag, "_ft"},   8'(frame_tick), 8'h00);
        chk({tag, "_chg"},  8'(changed),    8'h00);
    endtask

    initial begin
        // Idle scan after reset: 3 clocks per digit, tick when ch0 reloads
        tbl[0]  = '{4'b1110, 2'b00, 2'd0, 1'b0};
        tbl[1]  = '{4'b1110, 2'b00, 2'd0, 1'b0};
        tbl[2]  = '{4'b1110, 2'b00, 2'd0, 1'b0};
        tbl[3]  = '{4'b1101, 2'b00, 2'd1, 1'b0};
        tbl[4]  = '{4'b1101, 2'b00, 2'd1, 1'b0};
        tbl[5]  = '{4'b1101, 2'b00, 2'd1, 1'b0};
        tbl[6]  = '{4'b1011, 2'b00, 2'd2, 1'b0};
        tbl[7]  = '{4'b1011, 2'b00, 2'd2, 1'b0};
        tbl[8]  = '{4'b1011, 2'b00, 2'd2, 1'b0};
        tbl[9]  = '{4'b0111, 2'b00, 2'd3, 1'b0};
        tbl[10] = '{4'b0111, 2'b00, 2'd3, 1'b0};
        tbl[11] = '{4'b0111, 2'b00, 2'd3, 1'b0};
        tbl[12] = '{4'b1110, 2'b00, 2'd0, 1'b1};
        tbl[13] = '{4'b1110, 2'b00, 2'd0, 1'b0};

        reset_n     = 1'b0;
        enable      = 1'b0;
        std_in      = 8'h00;
        upd_req     = 1'b0;
        clr_changed = 1'b0;

        step();
        step();
        chk_reset_vals("rst");

        // ---- Reset/idle scan ----
        reset_n = 1'b1;
        enable  = 1'b1;
        s = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("idle_dig", 8'(dig_sel),    8'(tbl[i].dig));
            chk("idle_so",  8'(std_out),    8'(tbl[i].so));
            chk("idle_ch",  8'(ch_idx),     8'(tbl[i].ch));
            chk("idle_ft",  8'(frame_tick), 8'(tbl[i].ft));
            chk("idle_ack", 8'(upd_ack),    8'h00);
        end

        // ---- Snapshot at boundary: request mid-frame, ack only at s=25 ----
        run_to(18);
        std_in  = 8'b11_10_01_00;
        upd_req = 1'b1;
        while (s < 25) begin
            step();
            chk("bnd_ack", 8'(upd_ack), (s == 25) ? 8'h01 : 8'h00);
        end
        upd_req = 1'b0;
        chk("bnd_ft",  8'(frame_tick), 8'h01);
        chk("bnd_chg", 8'(changed),    8'b0000_1110);
        chk("bnd_so0", 8'(std_out),    8'h00);
        chk("bnd_dig0", 8'(dig_sel),   8'b0000_1110);
        step();
        chk("bnd_ack_pulse", 8'(upd_ack), 8'h00);
        // Phase turned hidden at s=25 (second tick), so changed digits blank
        run_to(29);
        chk("bnd_so1",  8'(std_out), 8'h01);
        chk("bnd_ch1",  8'(ch_idx),  8'h01);
        chk("blk_dig1_hidden", 8'(dig_sel), 8'b0000_1111);
        run_to(32);
        chk("bnd_so2",  8'(std_out), 8'h02);
        chk("blk_dig2_hidden", 8'(dig_sel), 8'b0000_1111);
        run_to(35);
        chk("bnd_so3",  8'(std_out), 8'h03);

        // ---- Blink windows: hidden 25..48, visible 49..72, hidden 73..96 ----
        run_to(41);
        chk("blk_f3_dig1", 8'(dig_sel), 8'b0000_1111);
        run_to(50);
        chk("blk_f4_dig0", 8'(dig_sel), 8'b0000_1110);
        run_to(53);
        chk("blk_f4_dig1", 8'(dig_sel), 8'b0000_1101);
        chk("blk_f4_so1",  8'(std_out), 8'h01);
        run_to(77);
        chk("blk_f6_dig1", 8'(dig_sel), 8'b0000_1111);
        run_to(78);
        clr_changed = 1'b1;
        step();
        clr_changed = 1'b0;
        chk("clr_chg", 8'(changed), 8'h00);
        run_to(89);
        chk("clr_dig1_steady", 8'(dig_sel), 8'b0000_1101);

        // ---- Set beats clear ----
        run_to(90);
        std_in  = 8'b11_01_01_00;          // ch2 10 -> 01
        upd_req = 1'b1;
        run_to(97);
        chk("sbc_ackA", 8'(upd_ack), 8'h01);
        chk("sbc_chgA", 8'(changed), 8'b0000_0100);
        upd_req     = 1'b0;
        clr_changed = 1'b1;
        step();
        clr_changed = 1'b0;
        chk("sbc_clr", 8'(changed), 8'h00);
        run_to(100);
        std_in  = 8'b00_01_01_00;          // ch3 11 -> 00
        upd_req = 1'b1;
        run_to(109);
        chk("sbc_ackC", 8'(upd_ack), 8'h01);
        chk("sbc_chgC", 8'(changed), 8'b0000_1000);
        upd_req = 1'b0;
        run_to(110);
        std_in  = 8'b00_10_01_00;          // ch2 01 -> 10
        upd_req = 1'b1;
        run_to(120);
        clr_changed = 1'b1;
        step();
        chk("sbc_ackB", 8'(upd_ack), 8'h01);
        chk("sbc_chgB", 8'(changed), 8'b0000_0100);
        upd_req     = 1'b0;
        clr_changed = 1'b0;

        // ---- Disabled handshake ----
        enable = 1'b0;
        step();
        chk("dis_dig", 8'(dig_sel),    8'b0000_1111);
        chk("dis_so",  8'(std_out),    8'h00);
        chk("dis_ch",  8'(ch_idx),     8'h00);
        chk("dis_ft",  8'(frame_tick), 8'h00);
        chk("dis_ack_idle", 8'(upd_ack), 8'h00);
        std_in  = 8'b00_11_00_10;
        upd_req = 1'b1;
        step();
        chk("dis_ack", 8'(upd_ack), 8'h01);
        chk("dis_chg", 8'(changed), 8'b0000_0111);
        chk("dis_dig_ack", 8'(dig_sel), 8'b0000_1111);
        chk("dis_so_ack",  8'(std_out), 8'h00);
        upd_req = 1'b0;
        step();
        chk("dis_ack_pulse", 8'(upd_ack), 8'h00);
        clr_changed = 1'b1;
        step();
        clr_changed = 1'b0;
        chk("dis_clr", 8'(changed), 8'h00);

        // Re-enable: ch0 for a full 3 clocks, then ch1
        enable = 1'b1;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ren_dig0", 8'(dig_sel), 8'b0000_1110);
            chk("ren_ch0",  8'(ch_idx),  8'h00);
            chk("ren_so0",  8'(std_out), 8'h02);
        end
        step();
        chk("ren_dig1", 8'(dig_sel), 8'b0000_1101);
        chk("ren_so1",  8'(std_out), 8'h00);

        // ---- Reset mid-operation at ch2 with a request pending ----
        run_to(7);
        chk("mid_ch2", 8'(ch_idx), 8'h02);
        std_in  = 8'b01_01_01_01;
        upd_req = 1'b1;
        reset_n = 1'b0;
        step();
        step();
        chk_reset_vals("mid_rst");
        reset_n = 1'b1;
        s = 0;
        while (s < 13) begin
            step();
            chk("mid_ack", 8'(upd_ack), (s == 13) ? 8'h01 : 8'h00);
        end
        upd_req = 1'b0;
        chk("mid_ft",  8'(frame_tick), 8'h01);
        chk("mid_chg", 8'(changed),    8'b0000_1111);
        chk("mid_so",  8'(std_out),    8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
